// File: rtl/axi_slave_mem.sv
// AXI4-subset memory slave: one write burst and one read burst in flight at once,
// backed by a word array. Errors are reported as SLVERR (2'b10) in BRESP/RRESP.
module axi_slave_mem #(
    parameter int MEM_DEPTH  = 4096,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [31:0]           WDATA,
    input  logic                  WVALID,
    input  logic                  WLAST,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [31:0]           RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [31:0] mem [MEM_DEPTH];

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic req_error(input logic [2:0] size, input logic [7:0] len,
                                       input logic [1:0] burst);
        return (size != 3'b010) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok(len));
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return a < MEM_BYTES;
    endfunction

    // For legal wrap lengths (len+1)*4-1 is exactly the in-window offset mask.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [7:0] len,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] step;
        mask = {{(ADDR_WIDTH-10){1'b0}}, len, 2'b11};
        step = a + ADDR_WIDTH'(4);
        if (burst == 2'b00)
            return a;
        else if (burst == 2'b10 && wrap_len_ok(len))
            return (a & ~mask) | (step & mask);
        else
            return step;
    endfunction

    // ---------------- write path ----------------
    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [7:0]            w_cnt;
    logic [1:0]            w_burst;
    logic                  w_err;
    logic                  w_fire;
    logic                  w_last_beat;
    logic                  w_beat_err;

    assign w_fire      = WVALID && WREADY;
    assign w_last_beat = (w_cnt == w_len);
    assign w_beat_err  = !in_range(w_addr) || (WLAST != w_last_beat);

    always_ff @(posedge clk) begin
        if (w_fire && in_range(w_addr))
            mem[w_addr[IDX_W+1:2]] <= WDATA;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= 2'b00;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    AWREADY <= 1'b1;
                    if (AWVALID && AWREADY) begin
                        w_addr  <= AWADDR;
                        w_len   <= AWLEN;
                        w_burst <= AWBURST;
                        w_cnt   <= '0;
                        w_err   <= req_error(AWSIZE, AWLEN, AWBURST);
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_addr <= next_addr(w_addr, w_len, w_burst);
                        w_cnt  <= w_cnt + 8'd1;
                        w_err  <= w_err || w_beat_err;
                        // Beat count alone ends the burst; WLAST only feeds the error flag.
                        if (w_last_beat) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BRESP   <= (w_err || w_beat_err) ? 2'b10 : 2'b00;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [7:0]            r_cnt;
    logic [1:0]            r_burst;
    logic                  r_err;

    // r_addr always points at the beat after the one currently presented on R.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RDATA   <= '0;
            RRESP   <= 2'b00;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        r_addr  <= next_addr(ARADDR, ARLEN, ARBURST);
                        r_len   <= ARLEN;
                        r_burst <= ARBURST;
                        r_cnt   <= '0;
                        r_err   <= req_error(ARSIZE, ARLEN, ARBURST);
                        RDATA   <= in_range(ARADDR) ? mem[ARADDR[IDX_W+1:2]] : '0;
                        RRESP   <= (req_error(ARSIZE, ARLEN, ARBURST) || !in_range(ARADDR))
                                   ? 2'b10 : 2'b00;
                        RVALID  <= 1'b1;
                        RLAST   <= (ARLEN == 8'd0);
                        ARREADY <= 1'b0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            RDATA  <= in_range(r_addr) ? mem[r_addr[IDX_W+1:2]] : '0;
                            RRESP  <= (r_err || !in_range(r_addr)) ? 2'b10 : 2'b00;
                            RLAST  <= ((r_cnt + 8'd1) == r_len);
                            r_cnt  <= r_cnt + 8'd1;
                            r_addr <= next_addr(r_addr, r_len, r_burst);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomised bench for axi_slave_mem against a word-array reference model that
// derives every beat address and response directly from the burst rules.
`timescale 1ns/1ps
module tb_axi_slave_mem;
    localparam int DEPTH = 4096;
    localparam int AW    = 32;
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] AWADDR = '0;
    logic [7:0]    AWLEN = '0;
    logic [2:0]    AWSIZE = 3'b010;
    logic [1:0]    AWBURST = 2'b01;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [31:0]   WDATA = '0;
    logic          WVALID = 1'b0;
    logic          WLAST = 1'b0;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY = 1'b0;
    logic [AW-1:0] ARADDR = '0;
    logic [7:0]    ARLEN = '0;
    logic [2:0]    ARSIZE = 3'b010;
    logic [1:0]    ARBURST = 2'b01;
    logic          ARVALID = 1'b0;
    logic          ARREADY;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY = 1'b0;

    always #5 clk = ~clk;

    axi_slave_mem #(.MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [DEPTH];
    bit          known [DEPTH];
    logic [31:0] wbuf  [256];

    function automatic bit legal_wrap(input int len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

    function automatic bit bad_req(input logic [2:0] size, input int len, input logic [1:0] burst);
        return (size != 3'b010) || (burst == 2'b11) || (burst == 2'b10 && !legal_wrap(len));
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input logic [1:0] burst, input int i);
        logic [31:0] wsize;
        logic [31:0] base;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && legal_wrap(len)) begin
            wsize = 32'((len + 1) * 4);
            base  = start - (start % wsize);
            return base + (((start - base) + 32'(4 * i)) % wsize);
        end
        return start + 32'(4 * i);
    endfunction

    task automatic do_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int wlast_mode,
                            input int bready_delay, input string name);
        bit          err;
        logic [31:0] ea;
        logic [1:0]  exp_resp;
        int          t;
        err = bad_req(size, len, burst);
        @(negedge clk);
        AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < 100) begin @(negedge clk); t++; end
        if (!AWREADY) begin
            checks++; failures++;
            $display("FAIL %s aw_timeout awready=%b required=1", name, AWREADY);
            AWVALID = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        AWVALID = 1'b0;
        checks++;
        if (WREADY !== 1'b1 || AWREADY !== 1'b0) begin
            failures++;
            $display("FAIL %s aw_accept wready=%b awready=%b required 1/0", name, WREADY, AWREADY);
        end
        for (int i = 0; i <= len; i++) begin
            WDATA = wbuf[i]; WVALID = 1'b1;
            case (wlast_mode)
                1:       WLAST = 1'b0;
                2:       WLAST = (i == 0) || (i == len);
                default: WLAST = (i == len);
            endcase
            if (WLAST != (i == len)) err = 1'b1;
            t = 0;
            while (!WREADY && t < 100) begin @(negedge clk); t++; end
            if (!WREADY) begin
                checks++; failures++;
                $display("FAIL %s w_timeout beat=%0d wready=%b required=1", name, i, WREADY);
                WVALID = 1'b0;
                return;
            end
            @(posedge clk); @(negedge clk);
            ea = beat_addr(addr, len, burst, i);
            if (ea < LIMIT) begin
                model[ea >> 2] = wbuf[i];
                known[ea >> 2] = 1'b1;
            end else begin
                err = 1'b1;
            end
        end
        WVALID = 1'b0; WLAST = 1'b0;
        exp_resp = err ? 2'b10 : 2'b00;
        checks++;
        if (BVALID !== 1'b1 || WREADY !== 1'b0 || BRESP !== exp_resp) begin
            failures++;
            $display("FAIL %s b_resp bvalid=%b wready=%b bresp=%b required 1/0/%b",
                     name, BVALID, WREADY, BRESP, exp_resp);
        end
        for (int d = 0; d < bready_delay; d++) begin
            @(negedge clk);
            checks++;
            if (BVALID !== 1'b1 || AWREADY !== 1'b0) begin
                failures++;
                $display("FAIL %s b_hold bvalid=%b awready=%b required 1/0", name, BVALID, AWREADY);
            end
        end
        BREADY = 1'b1;
        @(posedge clk); @(negedge clk);
        BREADY = 1'b0;
        checks++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
            failures++;
            $display("FAIL %s b_done bvalid=%b awready=%b required 0/1", name, BVALID, AWREADY);
        end
        $display("WRITE %s addr=%h len=%0d burst=%0d bresp=%b", name, addr, len, burst, exp_resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input bit stall, input string name);
        bit          rq_err;
        bit          in_r;
        logic [31:0] ea;
        logic [31:0] hold_data;
        logic [1:0]  hold_resp;
        logic        hold_last;
        logic [1:0]  exp_resp;
        int          k;
        int          t;
        rq_err = bad_req(size, len, burst);
        @(negedge clk);
        ARADDR = addr; ARLEN = 8'(len); ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        t = 0;
        while (!ARREADY && t < 100) begin @(negedge clk); t++; end
        if (!ARREADY) begin
            checks++; failures++;
            $display("FAIL %s ar_timeout arready=%b required=1", name, ARREADY);
            ARVALID = 1'b0;
            return;
        end
        @(posedge clk); @(negedge clk);
        ARVALID = 1'b0;
        checks++;
        if (RVALID !== 1'b1 || ARREADY !== 1'b0) begin
            failures++;
            $display("FAIL %s r_latency rvalid=%b arready=%b required 1/0", name, RVALID, ARREADY);
        end
        k = 0;
        for (int i = 0; i <= len; i++) begin
            ea = beat_addr(addr, len, burst, i);
            in_r = (ea < LIMIT);
            forever begin
                RREADY = !stall || (k % 3 == 0);
                k++;
                if (RREADY) break;
                hold_data = RDATA; hold_resp = RRESP; hold_last = RLAST;
                @(posedge clk); @(negedge clk);
                checks++;
                if (RVALID !== 1'b1 || RDATA !== hold_data || RRESP !== hold_resp || RLAST !== hold_last) begin
                    failures++;
                    $display("FAIL %s r_hold beat=%0d rvalid=%b rdata=%h required rvalid=1 rdata=%h",
                             name, i, RVALID, RDATA, hold_data);
                end
            end
            exp_resp = (rq_err || !in_r) ? 2'b10 : 2'b00;
            checks++;
            if (RVALID !== 1'b1 || RLAST !== (i == len) || RRESP !== exp_resp) begin
                failures++;
                $display("FAIL %s r_beat beat=%0d rvalid=%b rlast=%b rresp=%b required 1/%b/%b",
                         name, i, RVALID, RLAST, RRESP, (i == len), exp_resp);
            end
            if (!in_r) begin
                checks++;
                if (RDATA !== 32'h0) begin
                    failures++;
                    $display("FAIL %s r_oob_data beat=%0d rdata=%h required=00000000", name, i, RDATA);
                end
            end else if (!rq_err && known[ea >> 2]) begin
                checks++;
                if (RDATA !== model[ea >> 2]) begin
                    failures++;
                    $display("FAIL %s r_data beat=%0d addr=%h rdata=%h required=%h",
                             name, i, ea, RDATA, model[ea >> 2]);
                end
            end
            @(posedge clk); @(negedge clk);
        end
        RREADY = 1'b0;
        checks++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL %s r_end rvalid=%b arready=%b required 0/1", name, RVALID, ARREADY);
        end
        $display("READ  %s addr=%h len=%0d burst=%0d stall=%0d", name, addr, len, burst, stall);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (AWREADY !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 || ARREADY !== 1'b0 ||
            RVALID !== 1'b0 || RLAST !== 1'b0 || BRESP !== 2'b00 || RRESP !== 2'b00 || RDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_values aw=%b w=%b b=%b ar=%b rv=%b rl=%b rdata=%h required all 0",
                     AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, RDATA);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (AWREADY !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_early awready=%b required=0", AWREADY);
        end
        @(posedge clk); #1;
        checks++;
        if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL reset_release awready=%b arready=%b required 1/1", AWREADY, ARREADY);
        end
        $display("RESET released");
    endtask

    task automatic test_incr();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h200 + 32'(i);
        do_write(32'h2000, 7, 3'b010, 2'b01, 0, 0, "incr_w");
        do_read (32'h2000, 7, 3'b010, 2'b01, 1'b0, "incr_r");
    endtask

    task automatic test_fixed();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h100 + 32'(i);
        do_write(32'h1000, 3, 3'b010, 2'b00, 0, 0, "fixed_w");
        checks++;
        if (model[32'h1000 >> 2] !== 32'h103) begin
            failures++;
            $display("FAIL fixed_model word=%h required=00000103", model[32'h1000 >> 2]);
        end
        do_read(32'h1000, 3, 3'b010, 2'b00, 1'b0, "fixed_r");
    endtask

    task automatic test_wrap();
        wbuf[0] = 32'hAAAA_0001; wbuf[1] = 32'hBBBB_0002;
        wbuf[2] = 32'hCCCC_0003; wbuf[3] = 32'hDDDD_0004;
        do_write(32'h3008, 3, 3'b010, 2'b10, 0, 0, "wrap_w");
        do_read (32'h3000, 3, 3'b010, 2'b01, 1'b0, "wrap_r");
        do_read (32'h3004, 3, 3'b010, 2'b10, 1'b1, "wrap_r2");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        do_write(32'h0800, 7, 3'b010, 2'b01, 0, 5, "bp_w");
        do_read (32'h0800, 7, 3'b010, 2'b01, 1'b1, "bp_r");
    endtask

    task automatic test_errors();
        wbuf[0] = 32'h1234_5678; wbuf[1] = 32'h9ABC_DEF0;
        do_write(32'h4000, 1, 3'b010, 2'b01, 0, 0, "err_oob_w");
        wbuf[0] = 32'hFEED_3FFC;
        do_write(32'h3FFC, 0, 3'b010, 2'b01, 0, 0, "edge_w");
        do_read (32'h3FFC, 1, 3'b010, 2'b01, 1'b0, "err_oob_r");
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        do_write(32'h0400, 3, 3'b010, 2'b01, 1, 0, "err_nolast_w");
        do_write(32'h0440, 3, 3'b010, 2'b01, 2, 0, "err_early_w");
        do_write(32'h0480, 3, 3'b001, 2'b01, 0, 0, "err_size_w");
        do_write(32'h04C0, 2, 3'b010, 2'b10, 0, 0, "err_wraplen_w");
        do_read (32'h04C0, 2, 3'b010, 2'b10, 1'b0, "err_wraplen_r");
        do_read (32'h0400, 1, 3'b010, 2'b11, 1'b0, "err_burst_r");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        do_write(32'h0A00, 3, 3'b010, 2'b01, 0, 0, "b2b_pre");
        fork
            do_write(32'h0B00, 15, 3'b010, 2'b01, 0, 1, "b2b_w");
            do_read (32'h0A00, 3,  3'b010, 2'b01, 1'b1, "b2b_r");
        join
        do_read(32'h0B00, 15, 3'b010, 2'b01, 1'b0, "b2b_chk");
    endtask

    task automatic test_random();
        logic [1:0]  burst;
        int          len;
        logic [31:0] addr;
        for (int n = 0; n < 12; n++) begin
            burst = 2'($urandom_range(0, 2));
            len   = int'($urandom_range(0, 15));
            if (burst == 2'b10) begin
                case ($urandom_range(0, 3))
                    0:       len = 1;
                    1:       len = 3;
                    2:       len = 7;
                    default: len = 15;
                endcase
            end
            addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
            for (int i = 0; i <= len; i++) wbuf[i] = $urandom;
            do_write(addr, len, 3'b010, burst, 0, int'($urandom_range(0, 2)), "rand_w");
            do_read (addr, len, 3'b010, burst, 1'($urandom_range(0, 1)), "rand_r");
        end
    endtask

    task automatic test_reset_mid_burst();
        int t;
        @(negedge clk);
        AWADDR = 32'h0100; AWLEN = 8'd3; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); @(negedge clk);
        AWVALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            WDATA = 32'h5150_0000 + 32'(i); WVALID = 1'b1; WLAST = 1'b0;
            @(posedge clk); @(negedge clk);
            model[(32'h0100 >> 2) + i] = 32'h5150_0000 + 32'(i);
            known[(32'h0100 >> 2) + i] = 1'b1;
        end
        WVALID = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (AWREADY !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 || ARREADY !== 1'b0 ||
            RVALID !== 1'b0 || RLAST !== 1'b0 || BRESP !== 2'b00 || RRESP !== 2'b00 || RDATA !== 32'h0) begin
            failures++;
            $display("FAIL midreset_async aw=%b w=%b b=%b ar=%b rv=%b rdata=%h required all 0",
                     AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (AWREADY !== 1'b0) begin
            failures++;
            $display("FAIL midreset_release_early awready=%b required=0", AWREADY);
        end
        @(posedge clk); #1;
        checks++;
        if (AWREADY !== 1'b1 || BVALID !== 1'b0) begin
            failures++;
            $display("FAIL midreset_release awready=%b bvalid=%b required 1/0", AWREADY, BVALID);
        end
        $display("RESET mid-burst after 2 beats");
        do_read(32'h0100, 1, 3'b010, 2'b01, 1'b0, "midreset_keep_r");
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h6000 + 32'(i);
        do_write(32'h0100, 3, 3'b010, 2'b01, 0, 0, "post_reset_w");
        do_read (32'h0100, 3, 3'b010, 2'b01, 1'b1, "post_reset_r");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        test_reset();
        test_incr();
        test_fixed();
        test_wrap();
        test_backpressure();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI4-subset memory slave: the responder end of the interface driven by `axi_master`. It accepts write and read bursts on the AW/W/B and AR/R channels and stores data in an internal word array. It runs one write burst and one read burst concurrently. It replaces the behavioural slave model in benches and serves as the on-chip scratch RAM behind the master.

## Interface
Parameters:
- `MEM_DEPTH`, 4096: number of 32-bit words. Valid byte addresses are 0x0000 to 4*MEM_DEPTH-1, i.e. 0x0000–0x3FFF by default.
- `ADDR_WIDTH`, 32: width of AWADDR/ARADDR.

Ports:
- `clk` in 1: single clock; all logic samples on the rising edge.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `AWADDR` in ADDR_WIDTH, `AWLEN` in 8, `AWSIZE` in 3, `AWBURST` in 2, `AWVALID` in 1: write address channel.
- `AWREADY` out 1: write address ready.
- `WDATA` in 32, `WVALID` in 1, `WLAST` in 1: write data channel.
- `WREADY` out 1: write data ready.
- `BRESP` out 2, `BVALID` out 1: write response. `BREADY` in 1.
- `ARADDR` in ADDR_WIDTH, `ARLEN` in 8, `ARSIZE` in 3, `ARBURST` in 2, `ARVALID` in 1: read address channel.
- `ARREADY` out 1: read address ready.
- `RDATA` out 32, `RRESP` out 2, `RLAST` out 1, `RVALID` out 1: read data channel. `RREADY` in 1.

## Operation
- Write FSM has three states:
  - W_IDLE: AWREADY=1. On AW handshake, capture addr, len and burst, clear the beat counter and the error flag, go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes WDATA to the current word (if in range), advances the address and increments the beat counter. On the beat where counter==AWLEN, go to W_RESP.
  - W_RESP: BVALID=1 and BRESP=error ? 2'b10 : 2'b00. Hold until BREADY, then go to W_IDLE.
- Read FSM has two states:
  - R_IDLE: ARREADY=1. On AR handshake, capture the request and load the first beat: RDATA, RRESP, RVALID=1, RLAST=(ARLEN==0). Go to R_DATA.
  - R_DATA: on each R handshake, either finish or load the next beat. If RLAST was set, clear RVALID/RLAST and go to R_IDLE. Otherwise load the next word; set RLAST when the next beat index == ARLEN.
- Address generation (byte address; word index = addr[..:2]; addr[1:0] ignored):
  - FIXED (2'b00): address does not change.
  - INCR (2'b01): address += 4 per beat.
  - WRAP (2'b10): wrap size = (len+1)*4 bytes; base = addr aligned down to wrap size; next = addr+4, and if next equals base+wrap size it becomes base.
  - WRAP with len not in {1,3,7,15}, or burst 2'b11: address as INCR, error flag set.
- AxSIZE != 3'b010 sets the error flag; the step stays 4 bytes.
- Out-of-range beat (addr ≥ 4*MEM_DEPTH):
  - Write: data discarded, error flag set.
  - Read: RDATA=0, RRESP=2'b10 for that beat only. Each other read beat carries its own RRESP; size/burst errors mark every beat 2'b10.
- WLAST protocol check:
  - WLAST=0 on the final beat, or WLAST=1 on an earlier beat, sets the error flag.
  - Burst length is always AWLEN+1 beats; WLAST never ends a burst early.
- Memory is not reset; contents are undefined until written.
- Read/write collision on the same word in the same cycle: the read returns the old data.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BRESP, RRESP = 2'b00; RDATA = 0. Both FSMs reset to idle.
- AWREADY and ARREADY rise at the first clk edge after reset_n deasserts.
- All outputs are registered.
- Write path:
  - AW handshake at edge N: AWREADY=0 and WREADY=1 from N.
  - Final W handshake at edge M: WREADY=0 and BVALID=1 from M.
  - B handshake at edge K: BVALID=0 and AWREADY=1 from K.
- Read path:
  - AR handshake at edge N: RVALID=1 with beat 0 from N, i.e. one-cycle latency.
  - One beat per cycle while RREADY=1.
  - While RVALID=1 and RREADY=0, RDATA, RRESP and RLAST hold stable.
  - After the last handshake, ARREADY=1 at the same edge.
- BVALID and RVALID never drop without a handshake.
- Reset mid-burst aborts both FSMs immediately. No response is issued; words already written stay written.

## Test plan
- INCR write: AWADDR=0x2000, AWLEN=7, data 0x200..0x207 → one BVALID with BRESP=00. INCR read of the same range → 8 beats 0x200..0x207, RLAST only on beat 7, RRESP=00.
- FIXED: write 0x1000, len 3, data 0x100..0x103 → word 0x1000=0x103. FIXED read at 0x1000, len 3 → 0x103 four times.
- WRAP write at 0x3008, len 3, data A,B,C,D → words 0x3008=A, 0x300C=B, 0x3000=C, 0x3004=D. INCR read from 0x3000, len 3 → C,D,A,B.
- Backpressure:
  - RREADY toggled 1,0,0,1,… during an 8-beat read → RDATA stable while stalled, no beats lost.
  - BREADY held low 5 cycles → BVALID stays 1 and AWREADY stays 0.
- Errors:
  - Write at 0x4000, len 1 → BRESP=10.
  - Read from 0x3FFC, len 1 → beat 0 is mem data with RRESP 00; beat 1 is 0 with RRESP 10.
  - WLAST missing on the final beat → BRESP=10.
- Reset: drop reset_n after 2 of 4 W beats → all outputs 0 asynchronously, AWREADY=1 one edge after release. A following INCR write/read completes correctly.
